// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, control-command patterns and the decode bundle shared by the decode stage.
package decode_pkg;
    localparam int DEF_OPC_W  = 4;
    localparam int DEF_IMM_W  = 12;
    localparam int DEF_REG_AW = 3;
    localparam int DEF_SEQ_W  = 8;

    typedef enum logic [3:0] {
        OPC_NOP, OPC_ARITH_2OP, OPC_ARITH_3OP, OPC_MOVI, OPC_ADDI, OPC_LD, OPC_ST, OPC_SHIFT,
        OPC_BEQ, OPC_BNE, OPC_BLT, OPC_J, OPC_CONTROL = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_func_e;

    typedef enum logic [1:0] {CTL_STC, CTL_STB, CTL_HALT, CTL_RST} ctl_e;

    typedef enum logic {ST_RUN, ST_HALTED} state_e;

    typedef struct packed {
        logic [2**DEF_OPC_W-1:0] cls;
        logic [2:0]              alu_func;
        logic [DEF_REG_AW-1:0]   dest;
        logic [DEF_REG_AW-1:0]   src1;
        logic [DEF_REG_AW-1:0]   src2;
        logic [DEF_IMM_W-1:0]    imm;
        logic                    movi_hi;
        logic [3:0]              ctl;
        logic [DEF_SEQ_W-1:0]    seq;
    } decode_bundle_t;

    // rst is alternating ones and zeros with the MSB set, for any immediate width
    function automatic logic [63:0] ctl_pat(ctl_e c, int w);
        logic [63:0] p;
        p = 64'(w % 2);
        for (int i = 0; i < w / 2; i++) p = (p << 2) | (w % 2 == 1 ? 64'd1 : 64'd2);
        return c == CTL_STC ? 64'd1 : c == CTL_STB ? 64'd2 : c == CTL_HALT ? (64'd1 << w) - 64'd1 : p;
    endfunction

    function automatic logic is_branch(logic [31:0] opc);
        return opc >= 32'(OPC_BEQ) && opc <= 32'(OPC_J);
    endfunction
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational raw-instruction to decode-bundle fields.
module decode_comb import decode_pkg::*; #(
    parameter int OPC_W  = DEF_OPC_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [OPC_W+IMM_W-1:0] instr,
    output logic [2**OPC_W-1:0]    cls,
    output logic [2:0]             alu_func,
    output logic [REG_AW-1:0]      dest,
    output logic [REG_AW-1:0]      src1,
    output logic [REG_AW-1:0]      src2,
    output logic [IMM_W-1:0]       imm,
    output logic                   movi_hi,
    output logic [3:0]             ctl
);
    localparam logic [IMM_W-1:0] STC_IMM  = IMM_W'(ctl_pat(CTL_STC, IMM_W));
    localparam logic [IMM_W-1:0] STB_IMM  = IMM_W'(ctl_pat(CTL_STB, IMM_W));
    localparam logic [IMM_W-1:0] HALT_IMM = IMM_W'(ctl_pat(CTL_HALT, IMM_W));
    localparam logic [IMM_W-1:0] RST_IMM  = IMM_W'(ctl_pat(CTL_RST, IMM_W));

    logic [OPC_W-1:0]  opc;
    logic [REG_AW-1:0] f2, f3;
    logic              br;

    always_comb begin
        opc      = instr[OPC_W+IMM_W-1 -: OPC_W];
        imm      = instr[IMM_W-1:0];
        dest     = imm[IMM_W-1 -: REG_AW];
        f2       = imm[IMM_W-1-REG_AW -: REG_AW];
        f3       = imm[IMM_W-1-2*REG_AW -: REG_AW];
        br       = is_branch(32'(opc));
        cls      = '0;
        cls[opc] = 1'b1;
        alu_func = imm[2:0];
        src1     = br ? dest : f2;
        src2     = br ? f2 : f3;
        movi_hi  = opc == OPC_W'(OPC_MOVI) && imm[IMM_W-1-REG_AW];
        ctl      = &opc ? {imm == RST_IMM, imm == HALT_IMM, imm == STB_IMM, imm == STC_IMM} : 4'b0;
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with 2-entry skid buffer, sequence tags, halt/resume and flush.
module decode_stage import decode_pkg::*; #(
    parameter int OPC_W  = DEF_OPC_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int SEQ_W  = DEF_SEQ_W
) (
    input  logic                   clk_pi,
    input  logic                   rst_pi,
    input  logic                   in_valid_pi,
    input  logic [OPC_W+IMM_W-1:0] in_instr_pi,
    output logic                   in_ready_po,
    input  logic                   flush_pi,
    input  logic                   resume_pi,
    input  logic                   out_ready_pi,
    output logic                   out_valid_po,
    output logic [2**OPC_W-1:0]    out_class_po,
    output logic [2:0]             out_alu_func_po,
    output logic [REG_AW-1:0]      out_dest_po,
    output logic [REG_AW-1:0]      out_src1_po,
    output logic [REG_AW-1:0]      out_src2_po,
    output logic [IMM_W-1:0]       out_imm_po,
    output logic                   out_movi_hi_po,
    output logic [3:0]             out_ctl_po,
    output logic [SEQ_W-1:0]       out_seq_po,
    output logic                   halted_po
);
    typedef struct packed {
        logic [2**OPC_W-1:0] cls;
        logic [2:0]          alu_func;
        logic [REG_AW-1:0]   dest;
        logic [REG_AW-1:0]   src1;
        logic [REG_AW-1:0]   src2;
        logic [IMM_W-1:0]    imm;
        logic                movi_hi;
        logic [3:0]          ctl;
        logic [SEQ_W-1:0]    seq;
    } bundle_t;

    logic [2**OPC_W-1:0] d_cls;
    logic [2:0]          d_alu;
    logic [REG_AW-1:0]   d_dest, d_src1, d_src2;
    logic [IMM_W-1:0]    d_imm;
    logic                d_movi_hi;
    logic [3:0]          d_ctl;
    bundle_t             dec, out_q, skid_q;
    logic                out_v, skid_v, acc, xfer, out_free;
    logic [SEQ_W-1:0]    seq_q;
    state_e              state, state_n;

    decode_comb #(.OPC_W(OPC_W), .IMM_W(IMM_W), .REG_AW(REG_AW)) u_dec (
        .instr(in_instr_pi), .cls(d_cls), .alu_func(d_alu), .dest(d_dest), .src1(d_src1),
        .src2(d_src2), .imm(d_imm), .movi_hi(d_movi_hi), .ctl(d_ctl)
    );

    assign dec         = '{d_cls, d_alu, d_dest, d_src1, d_src2, d_imm, d_movi_hi, d_ctl, seq_q};
    assign in_ready_po = ~skid_v & (state == ST_RUN);
    assign halted_po   = state == ST_HALTED;

    // flush wins over a same-cycle accept, so a dropped instruction neither tags nor halts
    always_comb begin
        acc      = in_valid_pi & in_ready_po & ~flush_pi;
        xfer     = out_v & out_ready_pi;
        out_free = ~out_v | xfer;
        state_n  = state == ST_RUN ? (acc && d_ctl[2] ? ST_HALTED : ST_RUN)
                                   : (resume_pi ? ST_RUN : ST_HALTED);
    end

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            state  <= ST_RUN;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
            seq_q  <= '0;
        end else begin
            state <= state_n;
            if (acc) seq_q <= seq_q + 1'b1;
            if (flush_pi) begin
                out_v  <= 1'b0;
                skid_v <= 1'b0;
            end else if (out_free) begin
                out_v  <= skid_v | acc;
                out_q  <= skid_v ? skid_q : acc ? dec : out_q;
                skid_v <= 1'b0;
            end else if (acc) begin
                skid_v <= 1'b1;
                skid_q <= dec;
            end
        end
    end

    assign out_valid_po    = out_v;
    assign out_class_po    = out_q.cls;
    assign out_alu_func_po = out_q.alu_func;
    assign out_dest_po     = out_q.dest;
    assign out_src1_po     = out_q.src1;
    assign out_src2_po     = out_q.src2;
    assign out_imm_po      = out_q.imm;
    assign out_movi_hi_po  = out_q.movi_hi;
    assign out_ctl_po      = out_q.ctl;
    assign out_seq_po      = out_q.seq;
endmodule
